// File: rtl/saturn_ctrl_unit.sv
// Saturn core control unit: program buffer drained by the bus controller, nibble fetch,
// PC tracking and decode of the P=n, LC and GOTO instructions for the debugger.
module saturn_ctrl_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic [1:0]  i_phase,
  input  logic [31:0] i_cycle_ctr,
  input  logic        i_bus_busy,
  output logic [4:0]  o_program_address,
  input  logic [4:0]  i_program_address,
  output logic [4:0]  o_program_data,
  output logic        o_no_read,
  input  logic [3:0]  i_nibble,
  output logic        o_error,
  output logic [19:0] o_current_pc,
  output logic [4:0]  o_alu_reg_dest,
  output logic [4:0]  o_alu_reg_src_1,
  output logic [4:0]  o_alu_reg_src_2,
  output logic [3:0]  o_alu_imm_value,
  output logic [4:0]  o_alu_opcode,
  output logic [3:0]  o_instr_type,
  output logic        o_instr_decoded
);

  typedef enum logic [2:0] {
    S_IDLE, S_P_N, S_LC_LEN, S_LC_DATA, S_GOTO_0, S_GOTO_1, S_GOTO_2
  } state_t;

  logic [4:0]  prog_q [32];
  logic [4:0]  prog_d [32];
  logic [4:0]  wp_q, wp_d;
  logic [19:0] pc_q, pc_d, cur_pc_q, cur_pc_d, base_q, base_d;
  logic        err_q, err_d, nib_vld_q, nib_vld_d, dec_q, dec_d;
  logic [3:0]  nib_q, nib_d, cnt_q, cnt_d, imm_q, imm_d, type_q, type_d;
  logic [7:0]  off_q, off_d;
  logic [4:0]  dest_q, dest_d, src1_q, src1_d, src2_q, src2_d, opc_q, opc_d;
  state_t      state_q, state_d;
  logic        no_read_s, read_s, decode_s, dbg_unused_s;
  logic [19:0] target_s;

  assign dbg_unused_s = ^{i_phase, i_cycle_ctr};
  assign no_read_s    = (i_program_address != wp_q) | i_bus_busy | err_q;
  assign read_s       = i_clk_en & i_phases[1] & ~no_read_s;
  assign decode_s     = i_clk_en & i_phases[2];
  // 12-bit two's complement offset, relative to the first offset nibble
  assign target_s     = base_q + {{8{nib_q[3]}}, nib_q, off_q};

  // Next-state: nibble fetch in the read phase, instruction decode in the decode phase
  always_comb begin
    prog_d    = prog_q;
    wp_d      = wp_q;
    pc_d      = pc_q;
    cur_pc_d  = cur_pc_q;
    base_d    = base_q;
    err_d     = err_q;
    nib_vld_d = nib_vld_q;
    dec_d     = dec_q;
    nib_d     = nib_q;
    cnt_d     = cnt_q;
    imm_d     = imm_q;
    type_d    = type_q;
    off_d     = off_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    opc_d     = opc_q;
    state_d   = state_q;
    if (read_s) begin
      nib_d     = i_nibble;
      nib_vld_d = 1'b1;
      pc_d      = pc_q + 20'd1;
      cur_pc_d  = (state_q == S_IDLE) ? pc_q : cur_pc_q;
      base_d    = (state_q == S_GOTO_0) ? pc_q : base_q;
    end else begin
      nib_d = nib_q;
    end
    if (decode_s) begin
      dec_d = 1'b0;
      if (nib_vld_q) begin
        nib_vld_d = 1'b0;
        case (state_q)
          S_IDLE: begin
            case (nib_q)
              4'h2:    state_d = S_P_N;
              4'h3:    state_d = S_LC_LEN;
              4'h6:    state_d = S_GOTO_0;
              default: begin
                err_d  = 1'b1;
                type_d = 4'hF;
              end
            endcase
          end
          S_P_N: begin
            dec_d = 1'b1; type_d = 4'h1; opc_d = 5'h01; dest_d = 5'h10;
            src1_d = 5'h1F; src2_d = 5'h1F; imm_d = nib_q;
            state_d = S_IDLE;
          end
          S_LC_LEN: begin
            cnt_d   = nib_q;
            state_d = S_LC_DATA;
          end
          S_LC_DATA: begin
            dec_d = 1'b1; type_d = 4'h2; opc_d = 5'h01; dest_d = 5'h02;
            src1_d = 5'h1F; src2_d = 5'h1F; imm_d = nib_q;
            if (cnt_q == 4'd0) begin
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          S_GOTO_0: begin
            off_d[3:0] = nib_q;
            state_d    = S_GOTO_1;
          end
          S_GOTO_1: begin
            off_d[7:4] = nib_q;
            state_d    = S_GOTO_2;
          end
          S_GOTO_2: begin
            dec_d = 1'b1; type_d = 4'h3; opc_d = 5'h02; dest_d = 5'h11;
            src1_d = 5'h1F; src2_d = 5'h1F; imm_d = nib_q;
            // hand the bus controller a LOAD_PC command with the new target
            prog_d[wp_q]         = 5'h14;
            prog_d[wp_q + 5'd1]  = {1'b0, target_s[3:0]};
            prog_d[wp_q + 5'd2]  = {1'b0, target_s[7:4]};
            prog_d[wp_q + 5'd3]  = {1'b0, target_s[11:8]};
            prog_d[wp_q + 5'd4]  = {1'b0, target_s[15:12]};
            prog_d[wp_q + 5'd5]  = {1'b0, target_s[19:16]};
            wp_d    = wp_q + 5'd6;
            pc_d    = target_s;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end else begin
      dec_d = dec_q;
    end
  end

  // State registers with asynchronous reset to the LOAD_PC 0 init program
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) prog_q[i] <= 5'h00;
      prog_q[0] <= 5'h14;
      wp_q      <= 5'd6;
      pc_q      <= 20'd0;
      cur_pc_q  <= 20'd0;
      base_q    <= 20'd0;
      err_q     <= 1'b0;
      nib_vld_q <= 1'b0;
      dec_q     <= 1'b0;
      nib_q     <= 4'h0;
      cnt_q     <= 4'h0;
      imm_q     <= 4'h0;
      type_q    <= 4'h0;
      off_q     <= 8'h00;
      dest_q    <= 5'h1F;
      src1_q    <= 5'h1F;
      src2_q    <= 5'h1F;
      opc_q     <= 5'h1F;
      state_q   <= S_IDLE;
    end else begin
      prog_q    <= prog_d;
      wp_q      <= wp_d;
      pc_q      <= pc_d;
      cur_pc_q  <= cur_pc_d;
      base_q    <= base_d;
      err_q     <= err_d;
      nib_vld_q <= nib_vld_d;
      dec_q     <= dec_d;
      nib_q     <= nib_d;
      cnt_q     <= cnt_d;
      imm_q     <= imm_d;
      type_q    <= type_d;
      off_q     <= off_d;
      dest_q    <= dest_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      opc_q     <= opc_d;
      state_q   <= state_d;
    end
  end

  assign o_program_address = wp_q;
  assign o_program_data    = prog_q[i_program_address];
  assign o_no_read         = no_read_s;
  assign o_error           = err_q;
  assign o_current_pc      = cur_pc_q;
  assign o_alu_reg_dest    = dest_q;
  assign o_alu_reg_src_1   = src1_q;
  assign o_alu_reg_src_2   = src2_q;
  assign o_alu_imm_value   = imm_q;
  assign o_alu_opcode      = opc_q;
  assign o_instr_type      = type_q;
  assign o_instr_decoded   = dec_q;

endmodule

// File: tb/tb_saturn_ctrl_unit.sv
// Bench for saturn_ctrl_unit: directed pins plus randomized bus cycles against an
// instruction-level reference model, compared on every falling clock edge.
module tb_saturn_ctrl_unit;

  logic        i_clk = 1'b0;
  logic        i_reset, i_clk_en, i_bus_busy;
  logic [3:0]  i_phases, i_nibble;
  logic [1:0]  i_phase;
  logic [31:0] i_cycle_ctr;
  logic [4:0]  i_program_address;
  logic [4:0]  o_program_address, o_program_data, o_alu_reg_dest, o_alu_reg_src_1;
  logic [4:0]  o_alu_reg_src_2, o_alu_opcode;
  logic [3:0]  o_alu_imm_value, o_instr_type;
  logic        o_no_read, o_error, o_instr_decoded;
  logic [19:0] o_current_pc;

  always #5 i_clk = ~i_clk;

  saturn_ctrl_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_phases(i_phases),
    .i_phase(i_phase), .i_cycle_ctr(i_cycle_ctr), .i_bus_busy(i_bus_busy),
    .o_program_address(o_program_address), .i_program_address(i_program_address),
    .o_program_data(o_program_data), .o_no_read(o_no_read), .i_nibble(i_nibble),
    .o_error(o_error), .o_current_pc(o_current_pc), .o_alu_reg_dest(o_alu_reg_dest),
    .o_alu_reg_src_1(o_alu_reg_src_1), .o_alu_reg_src_2(o_alu_reg_src_2),
    .o_alu_imm_value(o_alu_imm_value), .o_alu_opcode(o_alu_opcode),
    .o_instr_type(o_instr_type), .o_instr_decoded(o_instr_decoded)
  );

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // reference model: program buffer, pointers and the nibbles of the instruction in flight
  int m_prog [32];
  int m_wp, m_pc, m_cur, m_err, m_pend, m_pend_nib, m_pend_addr, m_addr1;
  int m_dest, m_src1, m_src2, m_imm, m_opc, m_type, m_dec;
  int m_q [$];

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_prog[i] = 0;
    m_prog[0] = 'h14;
    m_wp = 6; m_pc = 0; m_cur = 0; m_err = 0; m_pend = 0; m_addr1 = 0;
    m_dest = 'h1F; m_src1 = 'h1F; m_src2 = 'h1F; m_opc = 'h1F; m_imm = 0; m_type = 0; m_dec = 0;
    m_q.delete();
  endfunction

  function automatic int model_no_read();
    return ((int'(i_program_address) != m_wp) || i_bus_busy || (m_err != 0)) ? 1 : 0;
  endfunction

  function automatic void strobe(input int t, input int op, input int d, input int v);
    m_dec = 1; m_type = t; m_opc = op; m_dest = d; m_src1 = 'h1F; m_src2 = 'h1F; m_imm = v;
  endfunction

  function automatic void interpret();
    int sz, off, t;
    sz = m_q.size();
    case (m_q[0])
      2: if (sz == 2) begin
        strobe(1, 1, 'h10, m_q[1]);
        m_q.delete();
      end
      3: if (sz >= 3) begin
        strobe(2, 1, 'h02, m_q[sz-1]);
        if (sz == m_q[1] + 3) m_q.delete();
      end
      6: if (sz == 4) begin
        off = m_q[1] + 16 * m_q[2] + 256 * m_q[3];
        if (off >= 2048) off = off - 4096;
        t = (m_addr1 + off + 'h100000) % 'h100000;
        strobe(3, 2, 'h11, m_q[3]);
        m_prog[m_wp] = 'h14;
        for (int k = 0; k < 5; k++) m_prog[(m_wp + 1 + k) % 32] = (t >> (4 * k)) & 15;
        m_wp = (m_wp + 6) % 32;
        m_pc = t;
        m_q.delete();
      end
      default: begin
        m_err = 1;
        m_type = 15;
        m_q.delete();
      end
    endcase
  endfunction

  function automatic void model_edge();
    int nr;
    if (!i_reset) begin
      model_reset();
    end else if (i_clk_en) begin
      nr = model_no_read();
      if (i_phases[1] && nr == 0) begin
        if (m_q.size() == 0) m_cur = m_pc;
        m_pend = 1; m_pend_nib = int'(i_nibble); m_pend_addr = m_pc;
        m_pc = (m_pc + 1) % 'h100000;
      end
      if (i_phases[2]) begin
        m_dec = 0;
        if (m_pend != 0) begin
          m_pend = 0;
          m_q.push_back(m_pend_nib);
          if (m_q.size() == 2) m_addr1 = m_pend_addr;
          interpret();
        end
      end
    end
  endfunction

  // compare every DUT output against the model once per clock
  always @(negedge i_clk) begin
    if (check_en) begin
      chk("prog_addr", o_program_address, m_wp);
      chk("prog_data", o_program_data, m_prog[i_program_address]);
      chk("no_read", o_no_read, model_no_read());
      chk("error", o_error, m_err);
      chk("cur_pc", o_current_pc, m_cur);
      chk("dest", o_alu_reg_dest, m_dest);
      chk("src1", o_alu_reg_src_1, m_src1);
      chk("src2", o_alu_reg_src_2, m_src2);
      chk("imm", o_alu_imm_value, m_imm);
      chk("opcode", o_alu_opcode, m_opc);
      chk("type", o_instr_type, m_type);
      chk("decoded", o_instr_decoded, m_dec);
    end
  end

  task automatic clk1();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    model_reset();
    i_program_address = 5'd0;
    clk1();
    clk1();
    i_reset = 1'b1;
  endtask

  task automatic phase(input int p, input logic [3:0] nib, input bit rnd);
    if (rnd) begin
      while ($urandom_range(0, 4) == 0) begin
        i_clk_en = 1'b0;
        i_phases = 4'($urandom_range(0, 15));
        i_nibble = 4'($urandom);
        clk1();
      end
    end
    i_clk_en = 1'b1;
    i_phases = 4'b0001 << p;
    i_phase  = 2'(p);
    i_nibble = nib;
    i_cycle_ctr = i_cycle_ctr + 32'd1;
    clk1();
  endtask

  task automatic bus_cycle(input logic [3:0] nib, input bit rnd);
    if ((int'(i_program_address) != m_wp) && (!rnd || $urandom_range(0, 2) != 0))
      i_program_address = i_program_address + 5'd1;
    i_bus_busy = rnd && ($urandom_range(0, 9) == 0);
    for (int p = 0; p < 4; p++) phase(p, nib, rnd);
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    bus_cycle(4'(a), 1'b0); bus_cycle(4'(b), 1'b0);
    bus_cycle(4'(c), 1'b0); bus_cycle(4'(d), 1'b0);
  endtask

  task automatic check_entries(input int start, input int e0, input int e1, input int e2,
                               input int e3, input int e4, input int e5);
    int exp [6];
    exp = '{e0, e1, e2, e3, e4, e5};
    for (int k = 0; k < 6; k++) begin
      i_program_address = 5'(start + k);
      #1;
      chk("pin_entry", o_program_data, exp[k]);
    end
  endtask

  initial begin
    logic [3:0] nib;
    int r;
    i_reset = 1'b0; i_clk_en = 1'b0; i_bus_busy = 1'b0; i_phases = 4'h0; i_phase = 2'd0;
    i_cycle_ctr = 32'd0; i_program_address = 5'd0; i_nibble = 4'h0;
    model_reset();
    #1 check_en = 1'b1;
    clk1();
    i_reset = 1'b1;
    chk("pin_rst_data", o_program_data, 'h14);
    chk("pin_rst_waddr", o_program_address, 6);
    chk("pin_rst_noread", o_no_read, 1);
    chk("pin_rst_dest", o_alu_reg_dest, 'h1F);
    for (int a = 1; a < 6; a++) begin
      i_program_address = 5'(a);
      #1;
      chk("pin_rst_zero", o_program_data, 0);
    end
    i_program_address = 5'd6;
    #1 chk("pin_noread_idle", o_no_read, 0);

    bus_cycle(4'h2, 1'b0); bus_cycle(4'h5, 1'b0);
    chk("pin_p_dec", o_instr_decoded, 1);
    chk("pin_p_type", o_instr_type, 1);
    chk("pin_p_dest", o_alu_reg_dest, 'h10);
    chk("pin_p_imm", o_alu_imm_value, 5);
    chk("pin_p_op", o_alu_opcode, 1);
    chk("pin_p_pc", o_current_pc, 0);

    do_reset(); i_program_address = 5'd6;
    bus_cycle(4'h3, 1'b0); bus_cycle(4'h1, 1'b0); bus_cycle(4'hA, 1'b0);
    chk("pin_lc_dest", o_alu_reg_dest, 'h02);
    chk("pin_lc_imm_a", o_alu_imm_value, 'hA);
    bus_cycle(4'hB, 1'b0);
    chk("pin_lc_imm_b", o_alu_imm_value, 'hB);
    chk("pin_lc_dec", o_instr_decoded, 1);
    bus_cycle(4'h2, 1'b0);
    chk("pin_lc_next_pc", o_current_pc, 4);

    do_reset(); i_program_address = 5'd6;
    send(6, 4, 0, 0);
    chk("pin_goto_wp", o_program_address, 12);
    chk("pin_goto_noread", o_no_read, 1);
    chk("pin_goto_type", o_instr_type, 3);
    chk("pin_goto_dest", o_alu_reg_dest, 'h11);
    check_entries(6, 'h14, 5, 0, 0, 0, 0);
    i_program_address = 5'd12;
    #1 chk("pin_goto_drained", o_no_read, 0);
    bus_cycle(4'h2, 1'b0);
    chk("pin_goto_pc", o_current_pc, 5);

    do_reset(); i_program_address = 5'd6;
    send(6, 'hF, 0, 0);
    i_program_address = 5'd12;
    send(6, 'hF, 'hF, 'hF);
    chk("pin_back_wp", o_program_address, 18);
    check_entries(12, 'h14, 0, 1, 0, 0, 0);
    i_program_address = 5'd18;
    bus_cycle(4'h2, 1'b0);
    chk("pin_back_pc", o_current_pc, 'h10);

    do_reset(); i_program_address = 5'd6;
    send(6, 0, 0, 8);
    check_entries(6, 'h14, 1, 0, 8, 'hF, 'hF);
    i_program_address = 5'd12;
    bus_cycle(4'h2, 1'b0);
    chk("pin_wrap_pc", o_current_pc, 'hFF801);

    phase(0, 4'h9, 1'b0); phase(1, 4'h9, 1'b0);
    i_clk_en = 1'b0; i_phases = 4'b0100;
    clk1(); clk1(); clk1();
    chk("pin_frz_dec", o_instr_decoded, 0);
    phase(2, 4'h0, 1'b0);
    chk("pin_frz_release", o_instr_decoded, 1);
    chk("pin_frz_imm", o_alu_imm_value, 9);
    phase(3, 4'h0, 1'b0);

    bus_cycle(4'hF, 1'b0);
    chk("pin_err", o_error, 1);
    chk("pin_err_type", o_instr_type, 15);
    chk("pin_err_noread", o_no_read, 1);
    bus_cycle(4'h2, 1'b0); bus_cycle(4'h3, 1'b0);
    chk("pin_err_sticky", o_error, 1);
    do_reset();
    chk("pin_err_cleared", o_error, 0);

    for (int n = 0; n < 500; n++) begin
      if ((m_err != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 150) == 0))
        do_reset();
      if (m_q.size() == 0 && m_pend == 0) begin
        r = $urandom_range(0, 39);
        nib = (r < 13) ? 4'h2 : (r < 26) ? 4'h3 : (r < 38) ? 4'h6 : 4'($urandom);
      end else begin
        nib = 4'($urandom);
      end
      bus_cycle(nib, 1'b1);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
